// File: rtl/cas3_sort.sv
// Three-input descending compare-and-swap sorter with source indices and a registered output.
// Define CAS3_PIPELINE_EN to add stage registers after S1 and S2 (3-cycle latency).
module cas3_sort #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] a_new,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] c_new,
  output logic [1:0]       a_idx,
  output logic [1:0]       b_idx,
  output logic [1:0]       c_idx
);

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic [1:0]       idx;
  } ent_t;

  // Ties keep x on top, which makes the network stable.
  function automatic ent_t ce_hi(input ent_t x, input ent_t y);
    return (x.val >= y.val) ? x : y;
  endfunction

  function automatic ent_t ce_lo(input ent_t x, input ent_t y);
    return (x.val >= y.val) ? y : x;
  endfunction

  ent_t ent_a, ent_b, ent_c;
  assign ent_a = {a, 2'd0};
  assign ent_b = {b, 2'd1};
  assign ent_c = {c, 2'd2};

  ent_t max_d, max_q, mid_d, mid_q, min_d, min_q;
  logic vld_d, vld_q;

`ifdef CAS3_PIPELINE_EN
  ent_t s1_hi_d, s1_hi_q, s1_lo_d, s1_lo_q, s1_c_d, s1_c_q;
  ent_t s2_top_d, s2_top_q, s2_hi_d, s2_hi_q, s2_lo_d, s2_lo_q;
  logic s1_v_d, s1_v_q, s2_v_d, s2_v_q;

  always_comb begin
    s1_hi_d  = ce_hi(ent_a, ent_b);
    s1_lo_d  = ce_lo(ent_a, ent_b);
    s1_c_d   = ent_c;
    s1_v_d   = in_valid;
    s2_top_d = s1_hi_q;
    s2_hi_d  = ce_hi(s1_lo_q, s1_c_q);
    s2_lo_d  = ce_lo(s1_lo_q, s1_c_q);
    s2_v_d   = s1_v_q;
    vld_d    = s2_v_q;
    max_d    = max_q;
    mid_d    = mid_q;
    min_d    = min_q;
    if (s2_v_q) begin
      max_d = ce_hi(s2_top_q, s2_hi_q);
      mid_d = ce_lo(s2_top_q, s2_hi_q);
      min_d = s2_lo_q;
    end
  end

  // Intermediate stages load every cycle; the valid bits qualify them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hi_q  <= '0;
      s1_lo_q  <= '0;
      s1_c_q   <= '0;
      s1_v_q   <= 1'b0;
      s2_top_q <= '0;
      s2_hi_q  <= '0;
      s2_lo_q  <= '0;
      s2_v_q   <= 1'b0;
    end else begin
      s1_hi_q  <= s1_hi_d;
      s1_lo_q  <= s1_lo_d;
      s1_c_q   <= s1_c_d;
      s1_v_q   <= s1_v_d;
      s2_top_q <= s2_top_d;
      s2_hi_q  <= s2_hi_d;
      s2_lo_q  <= s2_lo_d;
      s2_v_q   <= s2_v_d;
    end
  end
`else
  ent_t s1_hi, s1_lo, s2_hi, s2_lo;

  always_comb begin
    s1_hi = ce_hi(ent_a, ent_b);
    s1_lo = ce_lo(ent_a, ent_b);
    s2_hi = ce_hi(s1_lo, ent_c);
    s2_lo = ce_lo(s1_lo, ent_c);
    vld_d = in_valid;
    max_d = max_q;
    mid_d = mid_q;
    min_d = min_q;
    if (in_valid) begin
      max_d = ce_hi(s1_hi, s2_hi);
      mid_d = ce_lo(s1_hi, s2_hi);
      min_d = s2_lo;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      mid_q <= '0;
      min_q <= '0;
      vld_q <= 1'b0;
    end else begin
      max_q <= max_d;
      mid_q <= mid_d;
      min_q <= min_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign a_new     = max_q.val;
  assign b_new     = mid_q.val;
  assign c_new     = min_q.val;
  assign a_idx     = max_q.idx;
  assign b_idx     = mid_q.idx;
  assign c_idx     = min_q.idx;

endmodule

// File: tb/tb_cas3_sort.sv
// Directed and random self-checking bench for cas3_sort (both builds via CAS3_PIPELINE_EN).
module tb_cas3_sort;
  localparam int W = 6;
`ifdef CAS3_PIPELINE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic         out_valid;
  logic [W-1:0] a_new, b_new, c_new;
  logic [1:0]   a_idx, b_idx, c_idx;
  logic [3*W+5:0] obs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic           v;
    logic [3*W+5:0] d;
    string          tag;
  } exp_t;

  typedef struct {
    logic              v;
    logic [2:0][W-1:0] t;
  } rnd_t;

  exp_t eq[$];
  rnd_t rq[$];
  logic           hv;
  logic [3*W+5:0] hd;

  cas3_sort #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .a_new(a_new), .b_new(b_new), .c_new(c_new),
    .a_idx(a_idx), .b_idx(b_idx), .c_idx(c_idx)
  );

  always #5 clk = ~clk;
  assign obs = {a_new, b_new, c_new, a_idx, b_idx, c_idx};

  // Drive one cycle; the expected output register follows LAT cycles behind the inputs.
  task automatic cyc(input logic v, input logic [W-1:0] ia, ib, ic,
                     input logic [W-1:0] ea, eb, ec, input logic [1:0] xa, xb, xc,
                     input string tag);
    exp_t e;
    in_valid = v;
    if (v) begin
      a = ia; b = ib; c = ic;
    end else begin
      a = 'x; b = 'x; c = 'x;
    end
    eq.push_back('{v, {ea, eb, ec, xa, xb, xc}, tag});
    @(posedge clk); #1;
    if (eq.size() == LAT) begin
      e = eq.pop_front();
      hv = e.v;
      if (e.v) hd = e.d;
      tag = e.tag;
    end else begin
      tag = "fill";
    end
    checks++;
    assert (out_valid === hv) else begin
      errors++;
      $error("FAIL %s out_valid got=%0b exp=%0b", tag, out_valid, hv);
    end
    checks++;
    assert (obs === hd) else begin
      errors++;
      $error("FAIL %s data got=%h exp=%h", tag, obs, hd);
    end
  endtask

  task automatic bub(input string tag);
    cyc(1'b0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, tag);
  endtask

  function automatic logic [W-1:0] pick(input logic [2:0][W-1:0] t, input logic [1:0] i);
    return (i == 2'd0) ? t[0] : (i == 2'd1) ? t[1] : t[2];
  endfunction

  task automatic rcyc(input logic v);
    rnd_t r;
    logic [2:0][W-1:0] t;
    logic ok;
    for (int k = 0; k < 3; k++) t[k] = W'($urandom);
    in_valid = v;
    a = t[0]; b = t[1]; c = t[2];
    rq.push_back('{v, t});
    @(posedge clk); #1;
    if (rq.size() == LAT) begin
      r = rq.pop_front();
      if (r.v) begin
        ok = out_valid && (a_new >= b_new) && (b_new >= c_new)
             && (a_idx < 2'd3) && (b_idx < 2'd3) && (c_idx < 2'd3)
             && (a_idx != b_idx) && (b_idx != c_idx) && (a_idx != c_idx)
             && (a_new == pick(r.t, a_idx)) && (b_new == pick(r.t, b_idx))
             && (c_new == pick(r.t, c_idx));
        checks++;
        assert (ok === 1'b1) else begin
          errors++;
          $error("FAIL random in=%h got=%h exp=sorted_permutation", r.t, obs);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    hv = 1'b0; hd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    assert ({out_valid, obs} === '0) else begin
      errors++;
      $error("FAIL reset_state got=%h exp=0", {out_valid, obs});
    end

    cyc(1, 5, 40, 17, 40, 17, 5, 2'd1, 2'd2, 2'd0, "fix_5_40_17");
    cyc(1, 63, 0, 31, 63, 31, 0, 2'd0, 2'd2, 2'd1, "fix_63_0_31");
    cyc(1, 9, 9, 9, 9, 9, 9, 2'd0, 2'd1, 2'd2, "tie_all9");
    cyc(1, 3, 20, 20, 20, 20, 3, 2'd1, 2'd2, 2'd0, "tie_bc");
    cyc(1, 7, 7, 2, 7, 7, 2, 2'd0, 2'd1, 2'd2, "tie_ab");
    cyc(1, 4, 1, 4, 4, 4, 1, 2'd0, 2'd2, 2'd1, "tie_ac");
    cyc(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, "all_zero");
    cyc(1, 63, 63, 63, 63, 63, 63, 2'd0, 2'd1, 2'd2, "all_max");
    // All permutations of {1,2,3} back to back.
    cyc(1, 1, 2, 3, 3, 2, 1, 2'd2, 2'd1, 2'd0, "perm_123");
    cyc(1, 1, 3, 2, 3, 2, 1, 2'd1, 2'd2, 2'd0, "perm_132");
    cyc(1, 2, 1, 3, 3, 2, 1, 2'd2, 2'd0, 2'd1, "perm_213");
    cyc(1, 2, 3, 1, 3, 2, 1, 2'd1, 2'd0, 2'd2, "perm_231");
    cyc(1, 3, 1, 2, 3, 2, 1, 2'd0, 2'd2, 2'd1, "perm_312");
    cyc(1, 3, 2, 1, 3, 2, 1, 2'd0, 2'd1, 2'd2, "perm_321");
    // Bubble pattern 1,0,1: output holds the first result through the gap.
    cyc(1, 10, 30, 20, 30, 20, 10, 2'd1, 2'd2, 2'd0, "bub_first");
    bub("bub_gap");
    cyc(1, 50, 12, 33, 50, 33, 12, 2'd0, 2'd2, 2'd1, "bub_second");
    repeat (LAT) bub("drain1");

    // Asynchronous reset in the middle of a valid stream.
    cyc(1, 11, 22, 33, 33, 22, 11, 2'd2, 2'd1, 2'd0, "pre_rst");
    in_valid = 1'b1; a = 6'd44; b = 6'd2; c = 6'd8;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({out_valid, obs} === '0) else begin
      errors++;
      $error("FAIL rst_async got=%h exp=0", {out_valid, obs});
    end
    @(posedge clk); #1;
    checks++;
    assert ({out_valid, obs} === '0) else begin
      errors++;
      $error("FAIL rst_hold got=%h exp=0", {out_valid, obs});
    end
    rst_n = 1'b1;
    eq.delete();
    hv = 1'b0; hd = '0;
    cyc(1, 5, 40, 17, 40, 17, 5, 2'd1, 2'd2, 2'd0, "post_rst");
    repeat (LAT) bub("drain2");

    for (int i = 0; i < 1000; i++) rcyc(1'b1);
    repeat (LAT) rcyc(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
